booth_datapath: RTL and testbench

- Radix-2 Booth multiplier datapath. It is the status-producing end of the existing multiplier controller handshake.
- Consumes the controller's enable_a / enable_b / enable_pp / load_p strobes. Returns the load_pp and count status bits that drive the controller's state transitions.
- Holds multiplicand, multiplier, partial product and step counter. Delivers a registered signed 2*WIDTH product.

---
 rtl/booth_datapath.sv | 109 ++++++++++
 tb/tb_booth_datapath.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/booth_datapath.sv
// booth_datapath: radix-2 Booth multiplier datapath driven by the multiplier controller strobes
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous reset, active-low
//   enable_a      controller: multiplicand register enable
//   enable_b      controller: multiplier register enable
//   enable_pp     controller: partial-product phase enable
//   load_p        controller: perform Booth step / product phase
//   multiplicand  signed operand A, sampled on capture
//   multiplier    signed operand Q, sampled on capture
//   load_pp       status: operands captured, ready for partial-product phase
//   count         status: iteration in progress
//   product       signed 2*WIDTH result, held until the next result
//   product_valid one-cycle pulse when product updates
//   op_count      (BOOTH_OPCOUNT_EN only) number of add/subtract steps in the current run
//
// Optional feature macro: BOOTH_OPCOUNT_EN adds the op_count output.
module booth_datapath #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable_a,
    input  logic                 enable_b,
    input  logic                 enable_pp,
    input  logic                 load_p,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 load_pp,
    output logic                 count,
    output logic [2*WIDTH-1:0]   product,
    output logic                 product_valid
`ifdef BOOTH_OPCOUNT_EN
    ,
    output logic [CNT_W-1:0]     op_count
`endif
);
    // a and pp carry one extra bit so that subtracting the most-negative multiplicand cannot overflow
    logic [WIDTH:0]   a, pp, pp_sum;
    logic [WIDTH-1:0] q;
    logic             q_m1;
    logic [CNT_W-1:0] counter;
    logic             step, step_idle, init, capture, last, do_op;

    always_comb begin
        step      = enable_pp & load_p & (counter != '0);
        step_idle = enable_pp & load_p & (counter == '0);
        init      = enable_pp & ~load_p;
        capture   = enable_a & enable_b & ~enable_pp;
        last      = counter == CNT_W'(1);
        do_op     = q[0] ^ q_m1;
        pp_sum    = (q[0] & ~q_m1) ? pp - a : (~q[0] & q_m1) ? pp + a : pp;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a             <= '0;
            pp            <= '0;
            q             <= '0;
            q_m1          <= 1'b0;
            counter       <= '0;
            load_pp       <= 1'b0;
            count         <= 1'b0;
            product       <= '0;
            product_valid <= 1'b0;
        end else begin
            product_valid <= 1'b0;
            if (step) begin
                // arithmetic right shift of {pp_sum, q, q_m1}
                pp      <= {pp_sum[WIDTH], pp_sum[WIDTH:1]};
                q       <= {pp_sum[0], q[WIDTH-1:1]};
                q_m1    <= q[0];
                counter <= counter - CNT_W'(1);
                if (last) begin
                    count         <= 1'b0;
                    product       <= {pp_sum, q[WIDTH-1:1]};
                    product_valid <= 1'b1;
                end
            end else if (init) begin
                pp      <= '0;
                counter <= CNT_W'(WIDTH);
                load_pp <= 1'b0;
                count   <= 1'b1;
            end else if (capture) begin
                a       <= {multiplicand[WIDTH-1], multiplicand};
                q       <= multiplier;
                q_m1    <= 1'b0;
                load_pp <= 1'b1;
            end else if (!step_idle) begin
                load_pp <= 1'b0;
                count   <= 1'b0;
            end
        end
    end

`ifdef BOOTH_OPCOUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            op_count <= '0;
        else if (step && do_op)
            op_count <= op_count + CNT_W'(1);
        else if (init)
            op_count <= '0;
    end
`endif

endmodule

// File: tb/tb_booth_datapath.sv
// tb_booth_datapath: randomized self-checking bench for booth_datapath against plain multiplication
module tb_booth_datapath;
    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable_a = 1'b0, enable_b = 1'b0, enable_pp = 1'b0, load_p = 1'b0;
    logic [WIDTH-1:0] multiplicand = '0, multiplier = '0;
    logic load_pp, count, product_valid;
    logic [2*WIDTH-1:0] product;
`ifdef BOOTH_OPCOUNT_EN
    logic [CNT_W-1:0] op_count;
`endif
    int checks = 0;
    int errors = 0;

    booth_datapath #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .reset(reset),
        .enable_a(enable_a),
        .enable_b(enable_b),
        .enable_pp(enable_pp),
        .load_p(load_p),
        .multiplicand(multiplicand),
        .multiplier(multiplier),
        .load_pp(load_pp),
        .count(count),
        .product(product),
        .product_valid(product_valid)
`ifdef BOOTH_OPCOUNT_EN
        ,
        .op_count(op_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*WIDTH-1:0] ref_product(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int sx, sy;
        sx = int'($signed(x));
        sy = int'($signed(y));
        return (2*WIDTH)'(sx * sy);
    endfunction

    // each Booth recoding digit that is nonzero costs one add or subtract
    function automatic int ref_ops(input logic [WIDTH-1:0] y);
        int n = 0;
        logic prev = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (y[i] != prev) n++;
            prev = y[i];
        end
        return n;
    endfunction

    task automatic set_ctl(input logic ea, input logic eb, input logic epp, input logic lp);
        enable_a = ea;
        enable_b = eb;
        enable_pp = epp;
        load_p = lp;
    endtask

    task automatic mult(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit partial);
        int pulses = 0;
        logic [2*WIDTH-1:0] exp = ref_product(x, y);
        @(negedge clk);
        multiplicand = x;
        multiplier = y;
        set_ctl(1, 1, 0, 0);
        @(negedge clk);
        check("load_pp_after_capture", load_pp, 1);
        if (partial) begin
            multiplicand = ~x;
            set_ctl(1, 0, 0, 0);
            @(negedge clk);
            check("load_pp_partial_a", load_pp, 0);
            multiplier = ~y;
            set_ctl(0, 1, 0, 0);
            @(negedge clk);
            check("load_pp_partial_b", load_pp, 0);
        end
        set_ctl(0, 0, 1, 0);
        @(negedge clk);
        check("count_after_init", count, 1);
        check("load_pp_after_init", load_pp, 0);
        set_ctl(0, 0, 1, 1);
        for (int i = 1; i <= WIDTH; i++) begin
            @(negedge clk);
            pulses += int'(product_valid);
            if (i < WIDTH) begin
                check("count_mid", count, 1);
                check("valid_mid", product_valid, 0);
            end
        end
        check("product", product, exp);
        check("valid_final", product_valid, 1);
        check("count_final", count, 0);
`ifdef BOOTH_OPCOUNT_EN
        check("op_count", op_count, 64'(ref_ops(y)));
`endif
        @(negedge clk);
        pulses += int'(product_valid);
        check("product_after_step_idle", product, exp);
        check("count_step_idle", count, 0);
        set_ctl(0, 0, 0, 0);
        @(negedge clk);
        pulses += int'(product_valid);
        check("valid_pulses", 64'(pulses), 1);
        check("product_held", product, exp);
    endtask

    initial begin
        #12;
        check("reset_product", product, 0);
        check("reset_valid", product_valid, 0);
        check("reset_count", count, 0);
        check("reset_load_pp", load_pp, 0);
        @(negedge clk);
        reset = 1'b1;
        mult(8'd3, 8'd5, 0);
        mult(8'hF9, 8'd6, 0);
        mult(8'h80, 8'h80, 0);
        mult(8'h00, 8'h7F, 0);
        mult(8'h7F, 8'h80, 1);
        for (int k = 0; k < 25; k++)
            mult(WIDTH'($urandom), WIDTH'($urandom), ($urandom_range(0, 3) == 0));
        // abort an iteration with reset after four steps
        mult(8'd9, 8'd11, 0);
        @(negedge clk);
        multiplicand = 8'd12;
        multiplier = 8'd12;
        set_ctl(1, 1, 0, 0);
        @(negedge clk);
        set_ctl(0, 0, 1, 0);
        @(negedge clk);
        set_ctl(0, 0, 1, 1);
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_product", product, 0);
        check("abort_valid", product_valid, 0);
        check("abort_count", count, 0);
        check("abort_load_pp", load_pp, 0);
`ifdef BOOTH_OPCOUNT_EN
        check("abort_op_count", op_count, 0);
`endif
        set_ctl(0, 0, 0, 0);
        @(negedge clk);
        check("abort_held_product", product, 0);
        reset = 1'b1;
        mult(8'd12, 8'd12, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
